// File: rtl/mod_trap_sequencer_pkg.sv
// Shared widths, CSR addresses, trap-state encoding and handler-address helper
// for the machine-mode trap entry sequencer.
package mod_trap_sequencer_pkg;

  localparam int XLEN           = 32;
  localparam int CSR_ADDR_WIDTH = 12;

  localparam logic [CSR_ADDR_WIDTH-1:0] MTVEC_ADDR  = 12'h305;
  localparam logic [CSR_ADDR_WIDTH-1:0] MEPC_ADDR   = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] MCAUSE_ADDR = 12'h342;
  localparam logic [CSR_ADDR_WIDTH-1:0] MTVAL_ADDR  = 12'h343;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  localparam logic [XLEN-1:0] WORD_ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [2:0] {
    TRAP_IDLE,
    TRAP_W_EPC,
    TRAP_W_CAUSE,
    TRAP_W_TVAL,
    TRAP_RD_TVEC,
    TRAP_REDIRECT
  } trap_state_e;

  // Only vectored mode with an interrupt cause offsets the base; reserved
  // modes fall back to direct. The shift drops cause[XLEN-1] by truncation.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input logic [XLEN-1:0] cause);
    logic [XLEN-1:0] base;
    base = mtvec & WORD_ALIGN_MASK;
    if (mtvec[1:0] == MTVEC_MODE_VECTORED && cause[XLEN-1])
      return base + (cause << 2);
    return base;
  endfunction

endpackage

// File: rtl/mod_trap_sequencer.sv
// Trap entry sequencer: commits mepc/mcause/mtval over the single CSR write
// port, reads mtvec and issues a one-cycle fetch redirect to the handler.
module mod_trap_sequencer
  import mod_trap_sequencer_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      trap_req_i,
  input  logic [XLEN-1:0]           trap_pc_i,
  input  logic [XLEN-1:0]           trap_cause_i,
  input  logic [XLEN-1:0]           trap_tval_i,
  output logic                      trap_ack_o,
  output logic                      busy_o,
  output logic                      redirect_valid_o,
  output logic [XLEN-1:0]           redirect_pc_o,
  input  logic [CSR_ADDR_WIDTH-1:0] pipe_csr_read_addr_i,
  input  logic                      pipe_csr_read_enable_i,
  input  logic [CSR_ADDR_WIDTH-1:0] pipe_csr_write_addr_i,
  input  logic [XLEN-1:0]           pipe_csr_write_val_i,
  input  logic                      pipe_csr_write_enable_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_read_addr_o,
  output logic                      csr_read_enable_o,
  input  logic [XLEN-1:0]           csr_read_val_i,
  output logic [CSR_ADDR_WIDTH-1:0] csr_write_addr_o,
  output logic [XLEN-1:0]           csr_write_val_o,
  output logic                      csr_write_enable_o
);

  trap_state_e     state;
  logic [XLEN-1:0] epc_q;
  logic [XLEN-1:0] cause_q;
  logic [XLEN-1:0] tval_q;
  logic [XLEN-1:0] target_q;
  logic            busy_q;
  logic            redirect_valid_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= TRAP_IDLE;
      epc_q            <= '0;
      cause_q          <= '0;
      tval_q           <= '0;
      target_q         <= '0;
      busy_q           <= 1'b0;
      redirect_valid_q <= 1'b0;
    end else begin
      case (state)
        TRAP_IDLE: begin
          if (trap_req_i) begin
            epc_q   <= trap_pc_i & WORD_ALIGN_MASK;
            cause_q <= trap_cause_i;
            tval_q  <= trap_tval_i;
            busy_q  <= 1'b1;
            state   <= TRAP_W_EPC;
          end
        end
        TRAP_W_EPC:   state <= TRAP_W_CAUSE;
        TRAP_W_CAUSE: state <= TRAP_W_TVAL;
        TRAP_W_TVAL:  state <= TRAP_RD_TVEC;
        TRAP_RD_TVEC: begin
          target_q         <= trap_target(csr_read_val_i, cause_q);
          redirect_valid_q <= 1'b1;
          state            <= TRAP_REDIRECT;
        end
        TRAP_REDIRECT: begin
          redirect_valid_q <= 1'b0;
          busy_q           <= 1'b0;
          state            <= TRAP_IDLE;
        end
        default: begin
          redirect_valid_q <= 1'b0;
          busy_q           <= 1'b0;
          state            <= TRAP_IDLE;
        end
      endcase
    end
  end

  // Port mux is combinational so IDLE pass-through has zero latency; reset
  // gates it so every output reads 0 while rst_i is high.
  always_comb begin
    trap_ack_o         = 1'b0;
    csr_read_addr_o    = '0;
    csr_read_enable_o  = 1'b0;
    csr_write_addr_o   = '0;
    csr_write_val_o    = '0;
    csr_write_enable_o = 1'b0;
    if (!rst_i) begin
      case (state)
        TRAP_IDLE: begin
          trap_ack_o         = trap_req_i;
          csr_read_addr_o    = pipe_csr_read_addr_i;
          csr_read_enable_o  = pipe_csr_read_enable_i;
          csr_write_addr_o   = pipe_csr_write_addr_i;
          csr_write_val_o    = pipe_csr_write_val_i;
          csr_write_enable_o = pipe_csr_write_enable_i & ~trap_req_i;
        end
        TRAP_W_EPC: begin
          csr_write_addr_o   = MEPC_ADDR;
          csr_write_val_o    = epc_q;
          csr_write_enable_o = 1'b1;
        end
        TRAP_W_CAUSE: begin
          csr_write_addr_o   = MCAUSE_ADDR;
          csr_write_val_o    = cause_q;
          csr_write_enable_o = 1'b1;
        end
        TRAP_W_TVAL: begin
          csr_write_addr_o   = MTVAL_ADDR;
          csr_write_val_o    = tval_q;
          csr_write_enable_o = 1'b1;
        end
        TRAP_RD_TVEC: begin
          csr_read_addr_o   = MTVEC_ADDR;
          csr_read_enable_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_valid_q ? target_q : '0;

endmodule

// File: tb/tb_mod_trap_sequencer.sv
// Directed bench for mod_trap_sequencer; the bench models the CSR register
// file and checks every cycle of the trap sequence against hand-computed values.
module tb_mod_trap_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        trap_req_i = 1'b0;
  logic [31:0] trap_pc_i = '0;
  logic [31:0] trap_cause_i = '0;
  logic [31:0] trap_tval_i = '0;
  logic        trap_ack_o;
  logic        busy_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;
  logic [11:0] pipe_csr_read_addr_i = '0;
  logic        pipe_csr_read_enable_i = 1'b0;
  logic [11:0] pipe_csr_write_addr_i = '0;
  logic [31:0] pipe_csr_write_val_i = '0;
  logic        pipe_csr_write_enable_i = 1'b0;
  logic [11:0] csr_read_addr_o;
  logic        csr_read_enable_o;
  logic [31:0] csr_read_val_i;
  logic [11:0] csr_write_addr_o;
  logic [31:0] csr_write_val_o;
  logic        csr_write_enable_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] csr_mem [0:4095];

  mod_trap_sequencer dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .trap_req_i              (trap_req_i),
    .trap_pc_i               (trap_pc_i),
    .trap_cause_i            (trap_cause_i),
    .trap_tval_i             (trap_tval_i),
    .trap_ack_o              (trap_ack_o),
    .busy_o                  (busy_o),
    .redirect_valid_o        (redirect_valid_o),
    .redirect_pc_o           (redirect_pc_o),
    .pipe_csr_read_addr_i    (pipe_csr_read_addr_i),
    .pipe_csr_read_enable_i  (pipe_csr_read_enable_i),
    .pipe_csr_write_addr_i   (pipe_csr_write_addr_i),
    .pipe_csr_write_val_i    (pipe_csr_write_val_i),
    .pipe_csr_write_enable_i (pipe_csr_write_enable_i),
    .csr_read_addr_o         (csr_read_addr_o),
    .csr_read_enable_o       (csr_read_enable_o),
    .csr_read_val_i          (csr_read_val_i),
    .csr_write_addr_o        (csr_write_addr_o),
    .csr_write_val_o         (csr_write_val_o),
    .csr_write_enable_o      (csr_write_enable_o)
  );

  always #5 clk_i = ~clk_i;

  // Register-file model: synchronous write, combinational read.
  always @(posedge clk_i)
    if (csr_write_enable_o) csr_mem[csr_write_addr_o] <= csr_write_val_o;

  assign csr_read_val_i = csr_read_enable_o ? csr_mem[csr_read_addr_o] : 32'h0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setMtvec(input logic [31:0] value);
    @(negedge clk_i);
    pipe_csr_write_addr_i   = 12'h305;
    pipe_csr_write_val_i    = value;
    pipe_csr_write_enable_i = 1'b1;
    @(negedge clk_i);
    pipe_csr_write_enable_i = 1'b0;
  endtask

  // Drives one trap from acceptance (cycle 0) through cycle 6 and checks
  // each cycle; optionally collides a pipeline write to mtvec with cycle 0.
  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] cause,
                               input logic [31:0] tval, input logic [31:0] exp_epc,
                               input logic [31:0] exp_target, input bit collide);
    @(negedge clk_i);
    trap_req_i   = 1'b1;
    trap_pc_i    = pc;
    trap_cause_i = cause;
    trap_tval_i  = tval;
    if (collide) begin
      pipe_csr_write_addr_i   = 12'h305;
      pipe_csr_write_val_i    = 32'hCAFEF00D;
      pipe_csr_write_enable_i = 1'b1;
    end
    #1;
    checkOutput("c0_ack", trap_ack_o, 1);
    checkOutput("c0_busy", busy_o, 0);
    checkOutput("c0_we", csr_write_enable_o, 0);
    @(negedge clk_i);
    trap_req_i = 1'b0;
    pipe_csr_write_enable_i = 1'b0;
    #1;
    checkOutput("c1_busy", busy_o, 1);
    checkOutput("c1_ack", trap_ack_o, 0);
    checkOutput("c1_we", csr_write_enable_o, 1);
    checkOutput("c1_waddr", csr_write_addr_o, 32'h341);
    checkOutput("c1_wval", csr_write_val_o, exp_epc);
    @(negedge clk_i); #1;
    checkOutput("c2_waddr", csr_write_addr_o, 32'h342);
    checkOutput("c2_wval", csr_write_val_o, cause);
    @(negedge clk_i); #1;
    checkOutput("c3_waddr", csr_write_addr_o, 32'h343);
    checkOutput("c3_wval", csr_write_val_o, tval);
    @(negedge clk_i); #1;
    checkOutput("c4_we", csr_write_enable_o, 0);
    checkOutput("c4_re", csr_read_enable_o, 1);
    checkOutput("c4_raddr", csr_read_addr_o, 32'h305);
    @(negedge clk_i); #1;
    checkOutput("c5_rv", redirect_valid_o, 1);
    checkOutput("c5_rpc", redirect_pc_o, exp_target);
    checkOutput("c5_busy", busy_o, 1);
    checkOutput("c5_re", csr_read_enable_o, 0);
    @(negedge clk_i); #1;
    checkOutput("c6_rv", redirect_valid_o, 0);
    checkOutput("c6_busy", busy_o, 0);
  endtask

  initial begin
    // Reset asserted mid-clock: outputs must clear immediately.
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_ack", trap_ack_o, 0);
    checkOutput("rst_rv", redirect_valid_o, 0);
    checkOutput("rst_rpc", redirect_pc_o, 0);
    checkOutput("rst_we", csr_write_enable_o, 0);
    checkOutput("rst_re", csr_read_enable_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    checkOutput("post_rst_busy", busy_o, 0);
    checkOutput("post_rst_we", csr_write_enable_o, 0);

    // Pass-through in IDLE.
    pipe_csr_read_addr_i   = 12'h300;
    pipe_csr_read_enable_i = 1'b1;
    pipe_csr_write_addr_i  = 12'h340;
    pipe_csr_write_val_i   = 32'h0000_0055;
    pipe_csr_write_enable_i = 1'b1;
    #1;
    checkOutput("pt_raddr", csr_read_addr_o, 32'h300);
    checkOutput("pt_re", csr_read_enable_o, 1);
    checkOutput("pt_waddr", csr_write_addr_o, 32'h340);
    checkOutput("pt_wval", csr_write_val_o, 32'h55);
    checkOutput("pt_we", csr_write_enable_o, 1);
    @(negedge clk_i);
    pipe_csr_read_enable_i  = 1'b0;
    pipe_csr_write_enable_i = 1'b0;
    #1;
    checkOutput("pt_mem", csr_mem[12'h340], 32'h55);

    // Direct-mode trap.
    setMtvec(32'h0000_1000);
    applyStimulus(32'h206, 32'h2, 32'hDEADBEEF, 32'h204, 32'h1000, 1'b0);
    checkOutput("mem_mepc", csr_mem[12'h341], 32'h204);
    checkOutput("mem_mcause", csr_mem[12'h342], 32'h2);
    checkOutput("mem_mtval", csr_mem[12'h343], 32'hDEADBEEF);

    // Vectored mode, interrupt and exception; then reserved mode.
    setMtvec(32'h0000_1001);
    applyStimulus(32'h400, 32'h8000_0007, 32'h0, 32'h400, 32'h101C, 1'b0);
    applyStimulus(32'h404, 32'h5, 32'h11, 32'h404, 32'h1000, 1'b0);
    setMtvec(32'h0000_1003);
    applyStimulus(32'h408, 32'h8000_0007, 32'h0, 32'h408, 32'h1000, 1'b0);

    // Collision with a pipeline write to mtvec in the acceptance cycle.
    applyStimulus(32'h50E, 32'h1, 32'h22, 32'h50C, 32'h1000, 1'b1);
    checkOutput("collide_mtvec", csr_mem[12'h305], 32'h1003);

    // Back-to-back traps with trap_req_i held.
    @(negedge clk_i);
    trap_req_i   = 1'b1;
    trap_pc_i    = 32'h100;
    trap_cause_i = 32'h3;
    trap_tval_i  = 32'h33;
    #1;
    checkOutput("b2b_c0_ack", trap_ack_o, 1);
    @(negedge clk_i);
    trap_pc_i    = 32'h200;
    trap_cause_i = 32'h6;
    trap_tval_i  = 32'h66;
    #1;
    checkOutput("b2b_c1_ack", trap_ack_o, 0);
    checkOutput("b2b_c1_wval", csr_write_val_o, 32'h100);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk_i); #1;
      checkOutput("b2b_held_ack", trap_ack_o, 0);
    end
    checkOutput("b2b_c5_rv", redirect_valid_o, 1);
    @(negedge clk_i);
    pipe_csr_read_addr_i   = 12'h341;
    pipe_csr_read_enable_i = 1'b1;
    #1;
    checkOutput("b2b_c6_ack", trap_ack_o, 1);
    checkOutput("b2b_c6_busy", busy_o, 0);
    checkOutput("b2b_c6_rdata", csr_read_val_i, 32'h100);
    @(negedge clk_i);
    trap_req_i = 1'b0;
    pipe_csr_read_enable_i = 1'b0;
    #1;
    checkOutput("b2b_c7_waddr", csr_write_addr_o, 32'h341);
    checkOutput("b2b_c7_wval", csr_write_val_o, 32'h200);
    for (int c = 8; c <= 12; c++) begin
      @(negedge clk_i); #1;
    end
    checkOutput("b2b_done_busy", busy_o, 0);
    checkOutput("b2b_mcause", csr_mem[12'h342], 32'h6);

    // Reset during W_CAUSE.
    @(negedge clk_i);
    trap_req_i   = 1'b1;
    trap_pc_i    = 32'h300;
    trap_cause_i = 32'h4;
    trap_tval_i  = 32'h44;
    #1;
    checkOutput("mid_c0_ack", trap_ack_o, 1);
    @(negedge clk_i);
    trap_req_i = 1'b0;
    @(negedge clk_i); #1;
    checkOutput("mid_c2_waddr", csr_write_addr_o, 32'h342);
    rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_we", csr_write_enable_o, 0);
    checkOutput("mid_rst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i); #1;
      checkOutput("mid_after_rv", redirect_valid_o, 0);
      checkOutput("mid_after_we", csr_write_enable_o, 0);
      checkOutput("mid_after_busy", busy_o, 0);
    end
    checkOutput("mid_mepc", csr_mem[12'h341], 32'h300);
    checkOutput("mid_mcause", csr_mem[12'h342], 32'h6);
    checkOutput("mid_mtval", csr_mem[12'h343], 32'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
